// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler.
// Arbiter state encoding plus default sizing parameters.
package tick_sched_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_st_e;

  localparam int DEF_PRESCALE = 10;
  localparam int DEF_N_CH     = 4;
  localparam int DEF_PW       = 8;

endpackage

// File: rtl/tick_sched_prescaler.sv
// Prescaler: divides mclk into a registered one-cycle tick.
// Ports: mclk, rst (async, active-low), en (run), tick (out).
module tick_prescaler
  import tick_sched_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic mclk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/tick_sched.sv
// Multi-channel periodic event scheduler with round-robin hand-off.
// Ports: mclk/rst/en, tick, cfg_* config handshake, evt_* event handshake, overrun.
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int N_CH     = DEF_N_CH,
  parameter int CHW      = 2,
  parameter int PW       = DEF_PW
) (
  input  logic            mclk,
  input  logic            rst,
  input  logic            en,
  output logic            tick,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [PW-1:0]   cfg_period,
  input  logic            cfg_enable,
  output logic            evt_valid,
  output logic [CHW-1:0]  evt_ch,
  input  logic            evt_ready,
  output logic [N_CH-1:0] overrun
);

  localparam logic [PW-1:0]  P_ONE = PW'(1);
  localparam logic [CHW-1:0] C_ONE = CHW'(1);

  logic [PW-1:0]   period_q [N_CH];
  logic [PW-1:0]   period_d [N_CH];
  logic [PW-1:0]   cnt_q    [N_CH];
  logic [PW-1:0]   cnt_d    [N_CH];
  logic [N_CH-1:0] chen_q, chen_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovr_q, ovr_d;
  logic [CHW-1:0]  rr_q, rr_d;
  logic [CHW-1:0]  evt_ch_q, evt_ch_d;
  arb_st_e         st_q, st_d;

  logic            cfg_xfer;
  logic            acc;
  logic [N_CH-1:0] cfg_hit;
  logic [N_CH-1:0] fire;
  logic [N_CH-1:0] clr;
  logic [N_CH-1:0] avail;
  logic            sel_hit;
  logic [CHW-1:0]  sel_ch;
  logic [CHW-1:0]  idx;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .mclk(mclk),
    .rst (rst),
    .en  (en),
    .tick(tick)
  );

  // Config never lands on a tick, so counting and config
  // never collide on the same channel in one cycle.
  assign cfg_ready = !(tick ||
    ((st_q == ST_OFFER) && (cfg_ch == evt_ch_q)));
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign acc       = (st_q == ST_OFFER) && evt_ready;

  always_comb begin
    cfg_hit = '0;
    fire    = '0;
    clr     = '0;
    for (int c = 0; c < N_CH; c++) begin
      cfg_hit[c] = cfg_xfer && (cfg_ch == CHW'(c));
      fire[c]    = tick && chen_q[c] &&
                   (period_q[c] != '0) && (cnt_q[c] == '0);
      clr[c]     = acc && (evt_ch_q == CHW'(c));
    end
  end

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    chen_d   = chen_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    for (int c = 0; c < N_CH; c++) begin
      if (cfg_hit[c]) begin
        period_d[c] = cfg_period;
        chen_d[c]   = cfg_enable;
        cnt_d[c]    = cfg_period - P_ONE;
        pend_d[c]   = 1'b0;
        ovr_d[c]    = 1'b0;
      end else begin
        if (fire[c]) begin
          cnt_d[c] = period_q[c] - P_ONE;
        end else if (tick && chen_q[c] &&
                     (period_q[c] != '0)) begin
          cnt_d[c] = cnt_q[c] - P_ONE;
        end
        // A fire racing an accept keeps pending set
        // and is not a lost event.
        if (fire[c]) begin
          pend_d[c] = 1'b1;
          if (pend_q[c] && !clr[c]) begin
            ovr_d[c] = 1'b1;
          end
        end else if (clr[c]) begin
          pend_d[c] = 1'b0;
        end
      end
    end
  end

  // A channel being reconfigured this cycle loses its
  // pending event, so it must not be picked for offer.
  assign avail = pend_q & ~cfg_hit;

  always_comb begin
    sel_hit = 1'b0;
    sel_ch  = rr_q;
    idx     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = rr_q + CHW'(i);
      if (avail[idx]) begin
        sel_hit = 1'b1;
        sel_ch  = idx;
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    evt_ch_d = evt_ch_q;
    rr_d     = rr_q;
    unique case (st_q)
      ST_IDLE: begin
        if (sel_hit) begin
          st_d     = ST_OFFER;
          evt_ch_d = sel_ch;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          st_d = ST_IDLE;
          rr_d = evt_ch_q + C_ONE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N_CH; c++) begin
        period_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      chen_q   <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
      rr_q     <= '0;
      evt_ch_q <= '0;
      st_q     <= ST_IDLE;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      chen_q   <= chen_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
      rr_q     <= rr_d;
      evt_ch_q <= evt_ch_d;
      st_q     <= st_d;
    end
  end

  assign evt_valid = (st_q == ST_OFFER);
  assign evt_ch    = evt_ch_q;
  assign overrun   = ovr_q;

endmodule
